// File: rtl/player_ground_collider.sv
// player_ground_collider
// Scans a platform table one entry per clock and reports the highest
// (smallest y) platform the player box can stand on. A platform counts when
// it overlaps the player horizontally (strict) and its top is no more than
// SNAP_TOL pixels above the player's bottom edge.
// Optional feature: define PLATFORM_MATCH_COUNT_EN to add the match_count
// output (number of matching entries found by the last scan).
module player_ground_collider #(
    parameter int MAX_PLATFORMS = 16,
    parameter int SNAP_TOL      = 2,
    localparam int IDX_W        = $clog2(MAX_PLATFORMS)
) (
    input  logic             clk_player_control,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [9:0]       wr_x0,
    input  logic [9:0]       wr_x1,
    input  logic [9:0]       wr_y,
    input  logic             wr_valid,
    input  logic             clear_all,
    input  logic             scan_start,
    input  logic [9:0]       player_pos_x,
    input  logic [9:0]       player_pos_y,
    input  logic [9:0]       player_w,
    input  logic [9:0]       player_h,
`ifdef PLATFORM_MATCH_COUNT_EN
    output logic [IDX_W:0]   match_count,
`endif
    output logic             scan_busy,
    output logic             scan_done,
    output logic [9:0]       collider_ground_h_player,
    output logic             is_collider_ground_player
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state, state_nxt;

    logic [9:0]         plat_x0 [MAX_PLATFORMS];
    logic [9:0]         plat_x1 [MAX_PLATFORMS];
    logic [9:0]         plat_y  [MAX_PLATFORMS];
    logic [MAX_PLATFORMS-1:0] plat_valid;

    logic [IDX_W-1:0]   scan_idx;
    logic [10:0]        px0, px1, pbot;
    logic               best_found, best_found_nxt;
    logic [9:0]         best_y, best_y_nxt;
    logic               last_idx;
    logic               hit;
    logic [11:0]        ent_top_tol;

`ifdef PLATFORM_MATCH_COUNT_EN
    logic [IDX_W:0]     cnt, cnt_nxt;
`endif

    // Entry valid bits: clear_all wins over a same-cycle write
    always_ff @(posedge clk_player_control or negedge reset_n) begin
        if (!reset_n) begin
            plat_valid <= '0;
        end else if (clear_all) begin
            plat_valid <= '0;
        end else if (wr_en) begin
            plat_valid[wr_idx] <= wr_valid;
        end
    end

    // Entry geometry storage; only meaningful while the valid bit is set
    always_ff @(posedge clk_player_control) begin
        if (wr_en && !clear_all) begin
            plat_x0[wr_idx] <= wr_x0;
            plat_x1[wr_idx] <= wr_x1;
            plat_y[wr_idx]  <= wr_y;
        end
    end

    // FSM state register
    always_ff @(posedge clk_player_control or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign last_idx = (scan_idx == IDX_W'(MAX_PLATFORMS - 1));

    // FSM next state; scan_start outside IDLE is simply not looked at
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (scan_start) state_nxt = SCAN;
            SCAN:    if (last_idx)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: DONE lasts exactly one cycle, so scan_done is a pulse
    always_comb begin
        scan_busy = (state != IDLE);
        scan_done = (state == DONE);
    end

    // Evaluate the entry under the scan pointer against the captured box
    always_comb begin
        ent_top_tol    = {2'b00, plat_y[scan_idx]} + 12'(SNAP_TOL);
        hit            = plat_valid[scan_idx]
                         && (px1 > {1'b0, plat_x0[scan_idx]})
                         && (px0 < {1'b0, plat_x1[scan_idx]})
                         && (ent_top_tol >= {1'b0, pbot});
        best_found_nxt = best_found | hit;
        best_y_nxt     = best_y;
        // strict less-than keeps the lower index on equal y
        if (hit && (!best_found || (plat_y[scan_idx] < best_y))) begin
            best_y_nxt = plat_y[scan_idx];
        end
`ifdef PLATFORM_MATCH_COUNT_EN
        cnt_nxt = cnt + {{IDX_W{1'b0}}, hit};
`endif
    end

    // Scan pointer and running best-match flag
    always_ff @(posedge clk_player_control or negedge reset_n) begin
        if (!reset_n) begin
            scan_idx   <= '0;
            best_found <= 1'b0;
`ifdef PLATFORM_MATCH_COUNT_EN
            cnt        <= '0;
`endif
        end else if (state == SCAN) begin
            scan_idx   <= scan_idx + IDX_W'(1);
            best_found <= best_found_nxt;
`ifdef PLATFORM_MATCH_COUNT_EN
            cnt        <= cnt_nxt;
`endif
        end else begin
            scan_idx   <= '0;
            best_found <= 1'b0;
`ifdef PLATFORM_MATCH_COUNT_EN
            cnt        <= '0;
`endif
        end
    end

    // Player box snapshot at scan start, and running best y
    always_ff @(posedge clk_player_control) begin
        if (state == IDLE && scan_start) begin
            px0  <= {1'b0, player_pos_x};
            px1  <= {1'b0, player_pos_x} + {1'b0, player_w};
            pbot <= {1'b0, player_pos_y} + {1'b0, player_h};
        end
        if (state == SCAN) begin
            best_y <= best_y_nxt;
        end
    end

    // Result registers load on entry to DONE and hold until the next scan
    always_ff @(posedge clk_player_control or negedge reset_n) begin
        if (!reset_n) begin
            is_collider_ground_player <= 1'b0;
            collider_ground_h_player  <= '0;
`ifdef PLATFORM_MATCH_COUNT_EN
            match_count               <= '0;
`endif
        end else if (state == SCAN && last_idx) begin
            is_collider_ground_player <= best_found_nxt;
            collider_ground_h_player  <= best_found_nxt ? best_y_nxt : 10'd0;
`ifdef PLATFORM_MATCH_COUNT_EN
            match_count               <= cnt_nxt;
`endif
        end
    end

endmodule
